dtd_bin_fetcher: RTL and testbench



---
 rtl/dtd_bin_fetcher.sv | 217 +++++++++++++++++++++
 tb/tb_dtd_bin_fetcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtd_bin_fetcher.sv
// rtl/dtd_bin_fetcher.sv - walks one compressed bin in DRAM and paces its words into DTD
// Optional perf counters (perf_cycles, perf_stall) are built when DTD_FETCH_PERF_EN is defined.
module dtd_bin_fetcher #(
  parameter int BIN_SIZE   = 400,
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_GAP  = 12,
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] bin_base,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [255:0]      mem_rsp_data,
  input  logic [3:0]        mem_rsp_enc,
  output logic [255:0]      dtd_data,
  output logic [3:0]        dtd_encoding,
  output logic              dtd_en,
  output logic              busy,
  output logic              done
`ifdef DTD_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam int GW  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int GAP_M1 = ISSUE_GAP - 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        consumed_q, consumed_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [259:0]      fifo_q [FIFO_DEPTH];
  logic [259:0]      fifo_d [FIFO_DEPTH];
  logic [255:0]      dtd_data_q, dtd_data_d;
  logic [3:0]        dtd_enc_q, dtd_enc_d;
  logic              dtd_en_q, dtd_en_d;
  logic              done_q, done_d;

  logic         in_fetch;
  logic         bin_open;
  logic [CW:0]  credit_used;
  logic         req_fire;
  logic         rsp_take;
  logic         push;
  logic         pop;
  logic [259:0] head;
  logic [3:0]   head_enc;
  logic [8:0]   head_size;

  assign in_fetch    = (state_q == S_FETCH);
  assign bin_open    = (consumed_q < 10'(BIN_SIZE));
  assign credit_used = CW1'(outstanding_q) + CW1'(count_q);

  // Credits cover both in-flight reads and buffered words, so a response always has a slot.
  assign mem_req_valid = in_fetch && bin_open && (credit_used < CW1'(FIFO_DEPTH));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_take      = mem_rsp_valid && (state_q != S_IDLE) && (outstanding_q != '0);
  assign push          = rsp_take && in_fetch;
  assign pop           = in_fetch && (gap_q == '0) && (count_q != '0) && bin_open;

  assign head      = fifo_q[rd_ptr_q];
  assign head_enc  = head[3:0];
  assign head_size = (head_enc == 4'd0) ? 9'd32 : {4'b0000, head_enc, 1'b0};

  assign mem_req_addr = addr_q;
  assign dtd_data     = dtd_data_q;
  assign dtd_encoding = dtd_enc_q;
  assign dtd_en       = dtd_en_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    consumed_d    = consumed_q;
    gap_d         = gap_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fifo_d        = fifo_q;
    dtd_data_d    = dtd_data_q;
    dtd_enc_d     = dtd_enc_q;
    dtd_en_d      = 1'b0;
    done_d        = 1'b0;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    if (gap_q != '0) gap_d = gap_q - GW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_FETCH;
          addr_d        = bin_base;
          consumed_d    = '0;
          outstanding_d = '0;
          gap_d         = '0;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          count_d       = '0;
        end
      end
      S_FETCH: begin
        if (req_fire) addr_d = addr_q + ADDR_W'(LINE_BYTES);
        if (push) begin
          fifo_d[wr_ptr_q] = {mem_rsp_data, mem_rsp_enc};
          wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_d   = rd_ptr_q + PW'(1);
          dtd_data_d = head[259:4];
          dtd_enc_d  = head_enc;
          dtd_en_d   = 1'b1;
          consumed_d = consumed_q + 10'(head_size);
          gap_d      = GW'(GAP_M1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        // Bin complete: leftover buffered words belong past the end of the bin.
        if (!bin_open) begin
          state_d  = S_DRAIN;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end
      end
      S_DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DTD_FETCH_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if ((state_q == S_IDLE) && start) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if ((state_q != S_IDLE) && (perf_cycles_q != '1))
        perf_cycles_d = perf_cycles_q + 32'd1;
      if (in_fetch && (gap_q == '0) && (count_q == '0) && bin_open && (perf_stall_q != '1))
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      consumed_q    <= '0;
      outstanding_q <= '0;
      gap_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fifo_q        <= '{default: '0};
      dtd_data_q    <= '0;
      dtd_enc_q     <= '0;
      dtd_en_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      consumed_q    <= consumed_d;
      outstanding_q <= outstanding_d;
      gap_q         <= gap_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fifo_q        <= fifo_d;
      dtd_data_q    <= dtd_data_d;
      dtd_enc_q     <= dtd_enc_d;
      dtd_en_q      <= dtd_en_d;
      done_q        <= done_d;
    end
  end

  // A push into a full buffer means the credit accounting is broken.
  assert property (@(posedge clk) disable iff (rst) !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_dtd_bin_fetcher.sv
// tb/tb_dtd_bin_fetcher.sv - directed bench for dtd_bin_fetcher with an in-order DRAM model
module tb_dtd_bin_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  bin_base = '0;
  logic         sel = 1'b0;
  logic         mem_req_ready = 1'b0;
  logic         mem_rsp_valid = 1'b0;
  logic [255:0] mem_rsp_data = '0;
  logic [3:0]   mem_rsp_enc = '0;

  logic         a_req_valid, b_req_valid, a_dtd_en, b_dtd_en, a_busy, b_busy, a_done, b_done;
  logic [31:0]  a_req_addr, b_req_addr;
  logic [255:0] a_dtd_data, b_dtd_data;
  logic [3:0]   a_dtd_enc, b_dtd_enc;

  dtd_bin_fetcher u_dut (
    .clk(clk), .rst(rst), .start(start && !sel), .bin_base(bin_base),
    .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready && !sel), .mem_req_addr(a_req_addr),
    .mem_rsp_valid(mem_rsp_valid && !sel), .mem_rsp_data(mem_rsp_data), .mem_rsp_enc(mem_rsp_enc),
    .dtd_data(a_dtd_data), .dtd_encoding(a_dtd_enc), .dtd_en(a_dtd_en), .busy(a_busy), .done(a_done)
  );

  dtd_bin_fetcher #(.ISSUE_GAP(50)) u_slow (
    .clk(clk), .rst(rst), .start(start && sel), .bin_base(bin_base),
    .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready && sel), .mem_req_addr(b_req_addr),
    .mem_rsp_valid(mem_rsp_valid && sel), .mem_rsp_data(mem_rsp_data), .mem_rsp_enc(mem_rsp_enc),
    .dtd_data(b_dtd_data), .dtd_encoding(b_dtd_enc), .dtd_en(b_dtd_en), .busy(b_busy), .done(b_done)
  );

  logic         m_req_valid, m_dtd_en, m_busy, m_done;
  logic [31:0]  m_req_addr;
  logic [255:0] m_dtd_data;
  logic [3:0]   m_dtd_enc;
  assign m_req_valid = sel ? b_req_valid : a_req_valid;
  assign m_req_addr  = sel ? b_req_addr  : a_req_addr;
  assign m_dtd_en    = sel ? b_dtd_en    : a_dtd_en;
  assign m_dtd_data  = sel ? b_dtd_data  : a_dtd_data;
  assign m_dtd_enc   = sel ? b_dtd_enc   : a_dtd_enc;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_done      = sel ? b_done      : a_done;

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [3:0]  enc;
  } rsp_t;

  rsp_t        pend[$];
  rsp_t        expq[$];
  rsp_t        e;
  logic [3:0]  enc_tab[$];
  logic [31:0] exp_base;
  int cyc = 0, lat = 2, acc = 0, pulses = 0, done_cnt = 0, done_cyc = 0, last_rsp_cyc = 0;
  int rsp_after = 0, occ = 0, occ_max = 0, over = 0, hold_cycles = 0, hold_bad = 0;
  int exp_gap = 12, exp_pulses = 13, last_pulse = 0, late_rsp = 0;
  bit hold_ready = 1'b0, saw_block = 1'b0, done_busy = 1'b0, done_prev_busy = 1'b0, busy_prev = 1'b0;
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DRAM model and output monitor: observe outputs, then drive the next cycle's inputs.
  always @(negedge clk) begin
    cyc++;
    if (m_dtd_en) begin
      check("pulse_has_entry", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("dtd_data", m_dtd_data, {8{e.addr}});
        check("dtd_encoding", m_dtd_enc, e.enc);
      end
      if (pulses > 0 && exp_gap > 0) check("issue_gap", cyc - last_pulse, exp_gap);
      last_pulse = cyc;
      pulses++;
    end
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_busy = m_busy;
      done_prev_busy = busy_prev;
    end
    busy_prev = m_busy;
    occ = acc - pulses;
    if (occ > occ_max) occ_max = occ;
    if (m_req_valid && occ >= 4) over++;
    if (m_busy && occ == 4 && !m_req_valid) saw_block = 1'b1;
    if (hold_ready && m_busy) begin
      hold_cycles++;
      if (!(m_req_valid === 1'b1 && m_req_addr === exp_base)) hold_bad++;
    end

    mem_rsp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data = {8{e.addr}};
      mem_rsp_enc = e.enc;
      last_rsp_cyc = cyc;
      if (pulses >= exp_pulses) rsp_after++;
      if (!m_busy) late_rsp++;
    end
    mem_req_ready = !hold_ready;
    if (!rst && m_req_valid && mem_req_ready) begin
      check("req_addr", m_req_addr, exp_base + 32 * acc);
      e.due = cyc + lat;
      e.addr = m_req_addr;
      e.enc = enc_tab[acc % enc_tab.size()];
      pend.push_back(e);
      expq.push_back(e);
      acc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic reset_model(input logic [31:0] base, input int gap, input int npulse);
    expq.delete();
    acc = 0; pulses = 0; done_cnt = 0; rsp_after = 0; occ_max = 0; over = 0;
    saw_block = 1'b0; hold_cycles = 0; hold_bad = 0; last_pulse = 0;
    exp_base = base; exp_gap = gap; exp_pulses = npulse; bin_base = base;
  endtask

  task automatic kick();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick(1);
    tick(5);
    check(tag, done_cnt, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_valid"}, m_req_valid, 0);
    check({tag, "_req_addr"}, m_req_addr, 0);
    check({tag, "_dtd_data"}, m_dtd_data, 0);
    check({tag, "_dtd_enc"}, m_dtd_enc, 0);
    check({tag, "_dtd_en"}, m_dtd_en, 0);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_done"}, m_done, 0);
  endtask

  int p0, late0;

  initial begin
    enc_tab = {4'd0};
    exp_base = '0;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // Uniform size-32 words, 2-cycle DRAM: 13 pulses, 12 cycles apart.
    reset_model(32'h1000, 12, 13);
    lat = 2;
    enc_tab = {4'd0};
    kick();
    wait_done("t1_done_once", 2000);
    check("t1_pulses", pulses, 13);
    check("t1_busy_at_done", done_busy, 0);
    check("t1_busy_before_done", done_prev_busy, 1);

    // Sizes 10,30,2 repeating: 378 after 27, 388 after 28, 418 after 29.
    reset_model(32'h4000, 12, 29);
    enc_tab = {4'd5, 4'd15, 4'd1};
    kick();
    wait_done("t2_done_once", 3000);
    check("t2_pulses", pulses, 29);
    check("t2_last_enc_held", m_dtd_enc, 4'd15);
    check("t2_last_data_held", m_dtd_data, {8{32'h4000 + 32'd896}});

    // Request channel back-pressured for 20 cycles.
    reset_model(32'h5000, 12, 13);
    enc_tab = {4'd0};
    hold_ready = 1'b1;
    kick();
    tick(19);
    check("t3_hold_cycles", hold_cycles, 20);
    check("t3_hold_valid_addr", hold_bad, 0);
    check("t3_no_pulse_in_hold", pulses, 0);
    hold_ready = 1'b0;
    wait_done("t3_done_once", 2000);
    check("t3_pulses", pulses, 13);

    // Slow consumer instance, 1-cycle DRAM: credit limit holds at 4.
    sel = 1'b1;
    reset_model(32'h6000, 50, 13);
    lat = 1;
    kick();
    wait_done("t4_done_once", 3000);
    check("t4_pulses", pulses, 13);
    check("t4_occ_max", occ_max, 4);
    check("t4_valid_over_credit", over, 0);
    check("t4_valid_low_when_full", saw_block, 1);
    sel = 1'b0;
    tick(2);

    // Long latency: the 13th pulse leaves three reads in flight.
    reset_model(32'h7000, 0, 13);
    lat = 200;
    kick();
    wait_done("t5_done_once", 3000);
    check("t5_pulses", pulses, 13);
    check("t5_drain_rsps", rsp_after, 3);
    check("t5_done_after_last_rsp", done_cyc > last_rsp_cyc, 1);

    // Reset in the middle of a fetch, with reads still in flight.
    reset_model(32'h2000, 12, 13);
    lat = 20;
    kick();
    tick(60);
    check("t6_pulses_before_rst", pulses > 0, 1);
    check("t6_pending_at_rst", pend.size() > 0, 1);
    late0 = late_rsp;
    rst = 1'b1;
    tick(1);
    check_outputs_zero("t6_rst");
    rst = 1'b0;
    p0 = pulses;
    tick(25);
    check("t6_no_pulse_after_rst", pulses, p0);
    check("t6_idle_after_rst", m_busy, 0);
    check("t6_late_rsp_seen", late_rsp > late0, 1);
    check("t6_pend_empty", pend.size(), 0);
    reset_model(32'h3000, 12, 13);
    lat = 2;
    kick();
    wait_done("t6_restart_done_once", 2000);
    check("t6_restart_pulses", pulses, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
